ram_mp: RTL and testbench
=========================

RAM_MP -- requirements
Module: ram_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter N_RD, default 2, number of independent read ports (1..8).
REQ-004 SHALL have parameter BYPASS, default 1; 1 = write-to-read forwarding, 0 = read returns pre-write data.
REQ-005 SHALL have port clock, input, 1, single clock; all state updates on posedge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port wr_addr, input, ADDR_W, write address.
REQ-009 SHALL have port wr_data, input, DATA_W, write data.
REQ-010 SHALL have port rd_en, input, N_RD, per-port read request.
REQ-011 SHALL have port rd_addr, input, N_RD*ADDR_W, packed per-port read addresses; port i at [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port rd_data, output, N_RD*DATA_W, packed per-port registered read data.
REQ-013 SHALL have port rd_valid, output, N_RD, per-port one-cycle valid pulse.
REQ-014 SHALL have port clr_req, input, 1, request to zero the whole array.
REQ-015 SHALL have port busy, output, 1, high while a clear sequence runs.

Function
REQ-016 SHALL implement a two-state FSM: IDLE, CLEAR.
REQ-017 In CLEAR, SHALL write 0 to address clr_cnt each cycle, clr_cnt counting 0..DEPTH-1, taking exactly DEPTH cycles.
REQ-018 SHALL go CLEAR->IDLE on the cycle clr_cnt = DEPTH-1 is written; busy SHALL deassert on the next clock edge.
REQ-019 In IDLE, clr_req=1 SHALL go to CLEAR with clr_cnt=0; busy high from the next edge.
REQ-020 clr_req while busy SHALL be ignored; no restart, no extension.
REQ-021 In IDLE, wr_en=1 SHALL write wr_data to memory[wr_addr] at the edge.
REQ-022 wr_en and clr_req together in IDLE: clear SHALL win, write SHALL be dropped.
REQ-023 While busy, wr_en SHALL be ignored, and rd_en SHALL be ignored (rd_valid stays 0).
REQ-024 Read latency SHALL be 1 cycle: rd_en[i] sampled at edge N gives rd_data[i] and rd_valid[i]=1 after edge N.
REQ-025 rd_valid[i] SHALL be 0 for any cycle without an accepted read on port i; rd_data[i] SHALL then hold its last value.
REQ-026 With BYPASS=1, a read accepted in the same cycle as an accepted write to the same address SHALL return wr_data; with BYPASS=0 it SHALL return the old word.
REQ-027 Multiple read ports addressing the same word SHALL all return identical data; read ports SHALL never stall one another.
REQ-028 Address arithmetic SHALL be modulo DEPTH; no out-of-range case exists.

Reset
REQ-029 reset SHALL force FSM to CLEAR, clr_cnt=0, busy=1, rd_valid=0, rd_data=0 immediately and asynchronously.
REQ-030 After reset deasserts, the array SHALL be zeroed by the normal CLEAR sequence (DEPTH cycles) before any access is accepted.
REQ-031 The memory array itself SHALL NOT be asynchronously reset.
REQ-032 reset mid-CLEAR SHALL restart the sequence from clr_cnt=0.

Structure
REQ-033 Package ram_mp_pkg SHALL hold the FSM state enum typedef (IDLE, CLEAR) and default parameter constants.
REQ-034 FSM and clr_cnt counter SHALL live in sub-module ram_mp_clear_seq (outputs busy, clr_we, clr_addr); ram_mp instantiates it once.

Verification
REQ-035 Reset release, defaults: busy=1 for exactly 16 cycles, then 0; read addr 0..15 on both ports -> all 8'h00.
REQ-036 Idle write addr 4 = 8'hA5, next cycle rd_en=2'b11, addr 4 on both -> one cycle later rd_data both 8'hA5, rd_valid=2'b11.
REQ-037 Same-cycle write addr 7 = 8'h3C and read addr 7 (old 8'h11) -> 8'h3C with BYPASS=1, 8'h11 with BYPASS=0.
REQ-038 clr_req with wr_en (addr 2, 8'hFF) in IDLE -> write dropped, busy 16 cycles, addr 2 reads 8'h00; clr_req pulsed mid-clear -> still 16 cycles.
REQ-039 Reads and writes issued while busy -> rd_valid stays 0, memory unchanged after clear ends (all 8'h00).
REQ-040 reset asserted at clr_cnt=9 -> outputs zero immediately, full 16-cycle clear after release; N_RD=4, DATA_W=16 build passes REQ-036.

Source files
------------

// File: rtl/ram_mp_pkg.sv
// Shared types and default sizing for the multi-port RAM with a hardware
// clear sequencer.
package ram_mp_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_N_RD   = 2;
   localparam int DEF_BYPASS = 1;

endpackage

// File: rtl/ram_mp_clear_seq.sv
// Clear sequencer: walks every address once, driving a zero-write strobe.
// Reset lands in CLEAR so the array is always scrubbed before first use.
module ram_mp_clear_seq
   import ram_mp_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              busy_q;

   // A request arriving while already clearing is ignored, so a sequence
   // can never be restarted or stretched except by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (clr_req) begin
                  state_q <= CLEAR;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            CLEAR: begin
               cnt_q <= cnt_q + ADDR_W'(1);
               if (cnt_q == LAST_ADDR) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign clr_we   = busy_q;
   assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_mp.sv
// Single-write, N-read synchronous RAM with registered read ports, optional
// write-to-read forwarding and a whole-array clear.
module ram_mp
   import ram_mp_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int N_RD   = DEF_N_RD,
   parameter int BYPASS = DEF_BYPASS
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [N_RD-1:0]          rd_en,
   input  logic [N_RD*ADDR_W-1:0]   rd_addr,
   output logic [N_RD*DATA_W-1:0]   rd_data,
   output logic [N_RD-1:0]          rd_valid,
   input  logic                     clr_req,
   output logic                     busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0]      mem [DEPTH];
   logic                   clrWe;
   logic [ADDR_W-1:0]      clrAddr;
   logic                   wrAccept;
   logic [N_RD*DATA_W-1:0] rdData_d;
   logic [N_RD*DATA_W-1:0] rdData_q;
   logic [N_RD-1:0]        rdValid_d;
   logic [N_RD-1:0]        rdValid_q;

   ram_mp_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clock    (clock),
      .reset    (reset),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_we   (clrWe),
      .clr_addr (clrAddr)
   );

   // A clear request in the same cycle as a write takes precedence.
   assign wrAccept = wr_en & ~busy & ~clr_req;

   always_ff @(posedge clock) begin
      if (clrWe) begin
         mem[clrAddr] <= '0;
      end else if (wrAccept) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Idle ports keep their previous data; only the valid strobe drops.
   always_comb begin
      rdData_d  = rdData_q;
      rdValid_d = '0;
      for (int i = 0; i < N_RD; i++) begin
         if (rd_en[i] && !busy) begin
            rdValid_d[i] = 1'b1;
            if (BYPASS != 0 && wrAccept && rd_addr[i*ADDR_W +: ADDR_W] == wr_addr) begin
               rdData_d[i*DATA_W +: DATA_W] = wr_data;
            end else begin
               rdData_d[i*DATA_W +: DATA_W] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdData_q  <= '0;
         rdValid_q <= '0;
      end else begin
         rdData_q  <= rdData_d;
         rdValid_q <= rdValid_d;
      end
   end

   assign rd_data  = rdData_q;
   assign rd_valid = rdValid_q;

endmodule

// File: tb/tb_ram_mp.sv
// Directed bench for ram_mp: default build, a no-forwarding build sharing the
// same stimulus, and a wide four-port build.
module tb_ram_mp;

   typedef struct {
      logic       wrEn;
      logic [3:0] wrAddr;
      logic [7:0] wrData;
      logic [1:0] rdEn;
      logic [3:0] rdAddr0;
      logic [3:0] rdAddr1;
      logic [1:0] expValid;
      logic [7:0] exp0;
      logic [7:0] exp1;
      logic [7:0] expNb0;
   } vec_t;

   logic        clock;
   logic        reset;
   logic        wrEn;
   logic [3:0]  wrAddr;
   logic [7:0]  wrData;
   logic [1:0]  rdEn;
   logic [7:0]  rdAddr;
   logic        clrReq;
   logic [15:0] rdData;
   logic [1:0]  rdValid;
   logic        busy;
   logic [15:0] rdDataNb;
   logic [1:0]  rdValidNb;
   logic        busyNb;

   logic        wWrEn;
   logic [3:0]  wWrAddr;
   logic [15:0] wWrData;
   logic [3:0]  wRdEn;
   logic [15:0] wRdAddr;
   logic        wClrReq;
   logic [63:0] wRdData;
   logic [3:0]  wRdValid;
   logic        wBusy;

   int passCnt  = 0;
   int totalCnt = 0;
   vec_t vecs[10];

   ram_mp dut (
      .clock(clock), .reset(reset), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
      .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData), .rd_valid(rdValid),
      .clr_req(clrReq), .busy(busy)
   );

   ram_mp #(.BYPASS(0)) dutNb (
      .clock(clock), .reset(reset), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
      .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdDataNb), .rd_valid(rdValidNb),
      .clr_req(clrReq), .busy(busyNb)
   );

   ram_mp #(.DATA_W(16), .N_RD(4)) dutW (
      .clock(clock), .reset(reset), .wr_en(wWrEn), .wr_addr(wWrAddr), .wr_data(wWrData),
      .rd_en(wRdEn), .rd_addr(wRdAddr), .rd_data(wRdData), .rd_valid(wRdValid),
      .clr_req(wClrReq), .busy(wBusy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
      totalCnt++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         passCnt++;
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      wrEn   = v.wrEn;
      wrAddr = v.wrAddr;
      wrData = v.wrData;
      rdEn   = v.rdEn;
      rdAddr = {v.rdAddr1, v.rdAddr0};
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Counts edges until busy drops, bounded so a stuck sequencer still ends.
   task automatic countBusy(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (busy && n < 40);
   endtask

   task automatic readAllZero(input string name);
      for (int a = 0; a < 16; a++) begin
         rdEn   = 2'b11;
         rdAddr = {4'(15 - a), 4'(a)};
         tick();
         checkOutput(name, {rdValid, rdData}, {2'b11, 16'h0000});
         checkOutput({name, "Nb"}, {rdValidNb, rdDataNb}, {2'b11, 16'h0000});
      end
      rdEn = 2'b00;
   endtask

   initial begin
      int n;
      int badValid;
      vec_t idleVec;

      idleVec = '{1'b0, 4'h0, 8'h00, 2'b00, 4'h0, 4'h0, 2'b00, 8'h00, 8'h00, 8'h00};
      vecs[0] = '{1'b1, 4'h4, 8'hA5, 2'b00, 4'h0, 4'h0, 2'b00, 8'h00, 8'h00, 8'h00};
      vecs[1] = '{1'b0, 4'h0, 8'h00, 2'b11, 4'h4, 4'h4, 2'b11, 8'hA5, 8'hA5, 8'hA5};
      vecs[2] = '{1'b0, 4'h0, 8'h00, 2'b00, 4'h0, 4'h0, 2'b00, 8'hA5, 8'hA5, 8'hA5};
      vecs[3] = '{1'b1, 4'h7, 8'h11, 2'b00, 4'h0, 4'h0, 2'b00, 8'hA5, 8'hA5, 8'hA5};
      vecs[4] = '{1'b1, 4'h7, 8'h3C, 2'b11, 4'h7, 4'h4, 2'b11, 8'h3C, 8'hA5, 8'h11};
      vecs[5] = '{1'b0, 4'h0, 8'h00, 2'b11, 4'h7, 4'h7, 2'b11, 8'h3C, 8'h3C, 8'h3C};
      vecs[6] = '{1'b0, 4'h0, 8'h00, 2'b10, 4'h0, 4'h4, 2'b10, 8'h3C, 8'hA5, 8'h3C};
      vecs[7] = '{1'b1, 4'hF, 8'h77, 2'b01, 4'hF, 4'h4, 2'b01, 8'h77, 8'hA5, 8'h00};
      vecs[8] = '{1'b0, 4'h0, 8'h00, 2'b01, 4'hF, 4'h4, 2'b01, 8'h77, 8'hA5, 8'h77};
      vecs[9] = '{1'b1, 4'h2, 8'h66, 2'b01, 4'h2, 4'h4, 2'b01, 8'h66, 8'hA5, 8'h00};

      reset = 1'b0;
      clrReq = 1'b0;
      applyStimulus(idleVec);
      wWrEn = 1'b0; wWrAddr = '0; wWrData = '0; wRdEn = '0; wRdAddr = '0; wClrReq = 1'b0;

      // Reset state and the post-reset scrub.
      #1 reset = 1'b1;
      #1;
      checkOutput("resetState", {busy, rdValid, rdData}, {1'b1, 2'b00, 16'h0000});
      checkOutput("resetStateW", {wBusy, wRdValid, wRdData}, {1'b1, 4'h0, 64'h0});
      tick();
      tick();
      reset = 1'b0;
      countBusy(n);
      checkOutput("resetBusyCycles", 80'(n), 80'(16));
      checkOutput("resetBusyNb", {79'h0, busyNb}, 80'h0);
      readAllZero("initZero");

      // Table-driven idle reads, writes and forwarding.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput($sformatf("vec%0d", i), {busy, rdValid, rdData},
                     {1'b0, vecs[i].expValid, vecs[i].exp1, vecs[i].exp0});
         checkOutput($sformatf("vecNb%0d", i), {busyNb, rdValidNb, rdDataNb},
                     {1'b0, vecs[i].expValid, vecs[i].exp1, vecs[i].expNb0});
      end
      applyStimulus(idleVec);

      // Clear beats a simultaneous write; the concurrent read sees old data.
      wrEn = 1'b1; wrAddr = 4'h2; wrData = 8'hFF; clrReq = 1'b1;
      rdEn = 2'b01; rdAddr = {4'h4, 4'h2};
      tick();
      checkOutput("clrWinsRead", {busy, rdValid, rdData[7:0]}, {1'b1, 2'b01, 8'h66});
      checkOutput("clrWinsReadNb", {busyNb, rdValidNb, rdDataNb[7:0]}, {1'b1, 2'b01, 8'h66});
      applyStimulus(idleVec);
      clrReq = 1'b0;

      // Traffic and a repeated clear request while busy.
      n = 0;
      badValid = 0;
      do begin
         clrReq = (n == 5);
         wrEn   = (n >= 2 && n <= 8) || n == 15;
         wrAddr = 4'h3;
         wrData = 8'h55;
         rdEn   = (n >= 2 && n <= 8) ? 2'b11 : 2'b00;
         rdAddr = {4'h3, 4'h3};
         tick();
         n++;
         if (rdValid != 2'b00 || rdValidNb != 2'b00) badValid++;
      end while (busy && n < 40);
      clrReq = 1'b0;
      applyStimulus(idleVec);
      checkOutput("clrBusyCycles", 80'(n), 80'(16));
      checkOutput("busyNoValid", 80'(badValid), 80'(0));
      readAllZero("afterClear");

      // Reset in the middle of a clear restarts the scrub.
      wrEn = 1'b1; wrAddr = 4'h9; wrData = 8'h42;
      tick();
      applyStimulus(idleVec);
      rdEn = 2'b11; rdAddr = {4'h9, 4'h9};
      tick();
      checkOutput("preRstRead", {rdValid, rdData}, {2'b11, 16'h4242});
      rdEn = 2'b00;
      clrReq = 1'b1;
      tick();
      clrReq = 1'b0;
      repeat (9) tick();
      checkOutput("holdDuringClr", {busy, rdValid, rdData}, {1'b1, 2'b00, 16'h4242});
      #2 reset = 1'b1;
      #1;
      checkOutput("midClrReset", {busy, rdValid, rdData}, {1'b1, 2'b00, 16'h0000});
      checkOutput("midClrResetNb", {busyNb, rdValidNb, rdDataNb}, {1'b1, 2'b00, 16'h0000});
      tick();
      reset = 1'b0;
      countBusy(n);
      checkOutput("rstClrCycles", 80'(n), 80'(16));
      rdEn = 2'b11; rdAddr = {4'h8, 4'h9};
      tick();
      checkOutput("addr9Scrubbed", {rdValid, rdData}, {2'b11, 16'h0000});
      rdEn = 2'b00;

      // Wide four-port build.
      checkOutput("wideIdle", {79'h0, wBusy}, 80'h0);
      wWrEn = 1'b1; wWrAddr = 4'h4; wWrData = 16'hBEEF;
      tick();
      wWrEn = 1'b0;
      wRdEn = 4'hF; wRdAddr = {4'h4, 4'h4, 4'h4, 4'h4};
      tick();
      checkOutput("wideSame", {wRdValid, wRdData}, {4'hF, {4{16'hBEEF}}});
      wRdEn = 4'h0;
      wWrEn = 1'b1; wWrAddr = 4'h1; wWrData = 16'h1234;
      tick();
      wWrEn = 1'b0;
      wRdEn = 4'hF; wRdAddr = {4'h0, 4'h1, 4'h4, 4'h1};
      tick();
      checkOutput("wideMixed", {wRdValid, wRdData}, {4'hF, 16'h0000, 16'h1234, 16'hBEEF, 16'h1234});
      wRdEn = 4'h0;
      tick();
      checkOutput("wideHold", {wRdValid, wRdData}, {4'h0, 16'h0000, 16'h1234, 16'hBEEF, 16'h1234});

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
